// File: rtl/im_arbiter_if.sv
// Instruction-memory arbiter bus: CPU fetch port, loader write port and memory side.
// The slave modport is the arbiter; master is whatever surrounds it (CPU, loader, memory).
interface im_arbiter_if #(
  parameter int data_size = 32,
  parameter int addr_size = 10
);
  logic                 fetch_req;
  logic [addr_size-1:0] fetch_addr;
  logic                 fetch_ack;
  logic                 fetch_valid;
  logic [data_size-1:0] fetch_data;

  logic                 wr_req;
  logic [addr_size-1:0] wr_addr;
  logic [data_size-1:0] wr_data;
  logic                 wr_ack;

  logic [addr_size-1:0] IM_address;
  logic                 IM_enable_mem;
  logic                 IM_enable_fetch;
  logic                 IM_enable_write;
  logic [data_size-1:0] IMin;
  logic [data_size-1:0] IMout;

  logic                 busy;

  modport slave (
    input  fetch_req, fetch_addr, wr_req, wr_addr, wr_data, IMout,
    output fetch_ack, fetch_valid, fetch_data, wr_ack,
           IM_address, IM_enable_mem, IM_enable_fetch, IM_enable_write, IMin, busy
  );

  modport master (
    output fetch_req, fetch_addr, wr_req, wr_addr, wr_data, IMout,
    input  fetch_ack, fetch_valid, fetch_data, wr_ack,
           IM_address, IM_enable_mem, IM_enable_fetch, IM_enable_write, IMin, busy
  );
endinterface

// File: rtl/im_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction memory between CPU fetches
// and loader writes; every memory-side and handshake output is registered.
module im_arbiter #(
  parameter int data_size = 32,
  parameter int addr_size = 10
) (
  input  logic        clk,
  input  logic        reset,
  im_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR_ISSUE} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_WRITE} grant_t;

  localparam logic [data_size-1:0] data_zero = '0;
  localparam logic [addr_size-1:0] addr_zero = '0;

  state_t state;
  grant_t last_grant;

  // NOTE: all state and outputs live in one clocked block with non-blocking
  // assignments, so every output is a flop and reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      last_grant          <= GRANT_FETCH;
      bus.IM_address      <= addr_zero;
      bus.IMin            <= data_zero;
      bus.IM_enable_mem   <= 1'b0;
      bus.IM_enable_fetch <= 1'b0;
      bus.IM_enable_write <= 1'b0;
      bus.fetch_ack       <= 1'b0;
      bus.wr_ack          <= 1'b0;
      bus.fetch_valid     <= 1'b0;
      bus.fetch_data      <= data_zero;
      bus.busy            <= 1'b0;
    end else begin
      // Handshake outputs are single-cycle pulses unless re-raised below.
      bus.fetch_ack   <= 1'b0;
      bus.wr_ack      <= 1'b0;
      bus.fetch_valid <= 1'b0;

      case (state)
        IDLE: begin
          // On a tie the side not served last wins.
          if (bus.wr_req && (!bus.fetch_req || last_grant == GRANT_FETCH)) begin
            bus.IM_address      <= bus.wr_addr;
            bus.IMin            <= bus.wr_data;
            bus.IM_enable_mem   <= 1'b1;
            bus.IM_enable_write <= 1'b1;
            bus.IM_enable_fetch <= 1'b0;
            bus.wr_ack          <= 1'b1;
            bus.busy            <= 1'b1;
            last_grant          <= GRANT_WRITE;
            state               <= WR_ISSUE;
          end else if (bus.fetch_req) begin
            bus.IM_address      <= bus.fetch_addr;
            bus.IM_enable_mem   <= 1'b1;
            bus.IM_enable_fetch <= 1'b1;
            bus.IM_enable_write <= 1'b0;
            bus.fetch_ack       <= 1'b1;
            bus.busy            <= 1'b1;
            last_grant          <= GRANT_FETCH;
            state               <= RD_ISSUE;
          end else begin
            bus.IM_enable_mem   <= 1'b0;
            bus.IM_enable_fetch <= 1'b0;
            bus.IM_enable_write <= 1'b0;
          end
        end

        RD_ISSUE: begin
          bus.IM_enable_mem   <= 1'b0;
          bus.IM_enable_fetch <= 1'b0;
          bus.IM_enable_write <= 1'b0;
          state               <= RD_DATA;
        end

        RD_DATA: begin
          // Memory output is valid one cycle after the read edge.
          bus.fetch_data  <= bus.IMout;
          bus.fetch_valid <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end

        WR_ISSUE: begin
          bus.IM_enable_mem   <= 1'b0;
          bus.IM_enable_fetch <= 1'b0;
          bus.IM_enable_write <= 1'b0;
          bus.busy            <= 1'b0;
          state               <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
// Directed bench for im_arbiter: transaction table through a memory model, plus
// hand-written sequences for arbitration, resets and held/dropped requests.
module tb_im_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  im_arbiter_if #(.data_size(DW), .addr_size(AW)) bus ();

  im_arbiter #(.data_size(DW), .addr_size(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: write at the write edge, read data one cycle later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!reset && bus.IM_enable_mem && bus.IM_enable_write) mem[bus.IM_address] <= bus.IMin;
    if (bus.IM_enable_mem && bus.IM_enable_fetch) bus.IMout <= mem[bus.IM_address];
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Invariants sampled every cycle away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("strobe_exclusive", {63'd0, bus.IM_enable_fetch & bus.IM_enable_write}, 64'd0);
      if (bus.IM_enable_fetch || bus.IM_enable_write)
        check("strobe_implies_mem", {63'd0, bus.IM_enable_mem}, 64'd1);
      if (bus.IM_enable_mem)
        check("mem_implies_busy", {63'd0, bus.busy}, 64'd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge where the next request may be posed.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    check("wr_ack_c1", {63'd0, bus.wr_ack}, 64'd1);
    check("wr_we_c1", {61'd0, bus.IM_enable_mem, bus.IM_enable_write, bus.IM_enable_fetch}, 64'd6);
    check("wr_addr_c1", {54'd0, bus.IM_address}, {54'd0, addr});
    check("wr_data_c1", {32'd0, bus.IMin}, {32'd0, data});
    bus.wr_req = 1'b0;
    tick();
    check("wr_ack_c2", {62'd0, bus.wr_ack, bus.busy}, 64'd0);
  endtask

  task automatic do_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    tick();
    check("rd_ack_c1", {63'd0, bus.fetch_ack}, 64'd1);
    check("rd_en_c1", {61'd0, bus.IM_enable_mem, bus.IM_enable_write, bus.IM_enable_fetch}, 64'd5);
    check("rd_addr_c1", {54'd0, bus.IM_address}, {54'd0, addr});
    bus.fetch_req = 1'b0;
    tick();
    check("rd_c2", {59'd0, bus.fetch_ack, bus.fetch_valid, bus.busy, bus.IM_enable_mem,
                    bus.IM_enable_fetch}, 64'b00100);
    tick();
    check("rd_valid_c3", {62'd0, bus.fetch_valid, bus.busy}, 64'b10);
    check("rd_data_c3", {32'd0, bus.fetch_data}, {32'd0, expected});
  endtask

  typedef struct {
    bit            is_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    string seq;
    int    n_ack;

    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;

    vecs[0]  = '{1'b1, 10'h005, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 10'h005, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 10'h3FC, 32'd1};
    vecs[3]  = '{1'b1, 10'h3FD, 32'd2};
    vecs[4]  = '{1'b1, 10'h3FE, 32'd3};
    vecs[5]  = '{1'b1, 10'h3FF, 32'd4};
    vecs[6]  = '{1'b0, 10'h3FC, 32'd1};
    vecs[7]  = '{1'b0, 10'h3FD, 32'd2};
    vecs[8]  = '{1'b0, 10'h3FE, 32'd3};
    vecs[9]  = '{1'b0, 10'h3FF, 32'd4};
    vecs[10] = '{1'b1, 10'h000, 32'hA5A5_0F0F};
    vecs[11] = '{1'b0, 10'h000, 32'hA5A5_0F0F};

    // Reset state, sampled while reset is still held.
    tick();
    tick();
    check("reset_outputs", {bus.IM_address, bus.IM_enable_mem, bus.IM_enable_fetch,
                            bus.IM_enable_write, bus.fetch_ack, bus.wr_ack,
                            bus.fetch_valid, bus.busy}, 64'd0);
    check("reset_data", {bus.IMin, bus.fetch_data}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_write) do_write(vecs[i].addr, vecs[i].data);
      else                  do_fetch(vecs[i].addr, vecs[i].data);
    end

    // Both requests held after reset: write first, then strict alternation.
    apply_reset();
    bus.wr_req     = 1'b1;
    bus.wr_addr    = 10'h010;
    bus.wr_data    = 32'h1234_5678;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h010;
    seq = "";
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.wr_ack && bus.fetch_ack) check("dual_ack", 64'd1, 64'd0);
      if (bus.wr_ack) seq = {seq, "W"};
      if (bus.fetch_ack) seq = {seq, "F"};
    end
    bus.wr_req    = 1'b0;
    bus.fetch_req = 1'b0;
    check("rr_count", 64'(seq.len()), 64'd7);
    check("rr_order_is_WFWFWFW", {63'd0, seq == "WFWFWFW"}, 64'd1);
    tick();
    tick();

    // Reset in RD_DATA aborts the fetch.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h005;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_rd_outputs", {60'd0, bus.fetch_valid, bus.busy, bus.IM_enable_mem,
                             bus.IM_enable_fetch}, 64'd0);
    check("rst_rd_data", {32'd0, bus.fetch_data}, 64'd0);
    reset = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.fetch_valid) n_ack++;
    end
    check("rst_rd_no_valid", 64'(n_ack), 64'd0);

    // Fetch raised during WR_ISSUE is granted at the end of the next IDLE cycle.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'h020;
    bus.wr_data = 32'hCAFE_F00D;
    tick();
    bus.wr_req     = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 10'h020;
    tick();
    check("held_idle_no_ack", {62'd0, bus.fetch_ack, bus.busy}, 64'd0);
    tick();
    check("held_ack", {63'd0, bus.fetch_ack}, 64'd1);
    bus.fetch_req = 1'b0;
    n_ack = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.fetch_ack) n_ack++;
      if (c == 1) check("held_data", {32'd0, bus.fetch_data}, 64'hCAFE_F00D);
    end
    check("held_single_ack", 64'(n_ack), 64'd1);

    // Request withdrawn before its grant leaves no trace.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'h030;
    bus.wr_data = 32'h0000_0030;
    tick();
    bus.wr_req    = 1'b0;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.fetch_ack || bus.busy || bus.IM_enable_mem) n_ack++;
    end
    check("dropped_req", 64'(n_ack), 64'd0);

    // Reset in WR_ISSUE drops the enables and blocks the pending write.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'h005;
    bus.wr_data = 32'h0BAD_0BAD;
    tick();
    bus.wr_req = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_wr_enables", {61'd0, bus.IM_enable_mem, bus.IM_enable_write, bus.busy}, 64'd0);

    // Reset beats simultaneous requests.
    bus.wr_req    = 1'b1;
    bus.fetch_req = 1'b1;
    tick();
    check("rst_priority", {61'd0, bus.wr_ack, bus.fetch_ack, bus.busy}, 64'd0);
    bus.wr_req    = 1'b0;
    bus.fetch_req = 1'b0;
    reset = 1'b0;
    tick();
    do_fetch(10'h005, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 Parameter data_size, default 32, instruction word width.
REQ-002 Parameter addr_size, default 10, instruction memory address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_req  input  1  CPU fetch request; held until fetch_ack.
REQ-006 fetch_addr  input  addr_size  fetch address; sampled on the grant edge.
REQ-007 fetch_ack  output  1  one-cycle pulse: fetch granted.
REQ-008 fetch_valid  output  1  one-cycle pulse: fetch_data valid.
REQ-009 fetch_data  output  data_size  fetched instruction; held until the next fetch_valid.
REQ-010 wr_req  input  1  loader write request; held until wr_ack.
REQ-011 wr_addr  input  addr_size  write address; sampled on the grant edge.
REQ-012 wr_data  input  data_size  write data; sampled on the grant edge.
REQ-013 wr_ack  output  1  one-cycle pulse: write issued.
REQ-014 IM_address  output  addr_size  memory address, registered.
REQ-015 IM_enable_mem  output  1  memory enable, registered.
REQ-016 IM_enable_fetch  output  1  memory read strobe, registered.
REQ-017 IM_enable_write  output  1  memory write strobe, registered.
REQ-018 IMin  output  data_size  memory write data, registered.
REQ-019 IMout  input  data_size  memory read data; valid the cycle after the read edge.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, RD_ISSUE, RD_DATA and WR_ISSUE.
REQ-022 In IDLE with no request: stay in IDLE, with IM_enable_mem, IM_enable_fetch and IM_enable_write all 0.
REQ-023 In IDLE with exactly one request: grant that requester at the clock edge.
REQ-024 In IDLE with both requests: grant the requester not served last (round-robin); the last_grant pointer resets to "fetch", so the write wins the first tie.
REQ-025 Fetch grant edge:
- IM_address <= fetch_addr, IM_enable_mem <= 1, IM_enable_fetch <= 1, IM_enable_write <= 0
- fetch_ack <= 1, last_grant <= fetch
- next state RD_ISSUE
REQ-026 RD_ISSUE:
- lasts one cycle; the memory reads at its closing edge
- at that edge, all enables <= 0 and the FSM goes to RD_DATA
REQ-027 RD_DATA: at its closing edge, fetch_data <= IMout, fetch_valid <= 1, next state IDLE.
REQ-028 Write grant edge:
- IM_address <= wr_addr, IMin <= wr_data, IM_enable_mem <= 1, IM_enable_write <= 1, IM_enable_fetch <= 0
- wr_ack <= 1, last_grant <= write
- next state WR_ISSUE
REQ-029 WR_ISSUE: lasts one cycle (the memory writes at its closing edge), then all enables <= 0 and the FSM returns to IDLE.
REQ-030 Latency, with the request sampled at the end of cycle 0:
- fetch: fetch_ack high in cycle 1, fetch_valid high in cycle 3
- write: wr_ack high in cycle 1, memory updated at the end of cycle 1
REQ-031 Throughput: at most one fetch per 3 cycles and one write per 2 cycles; a new grant is possible on the edge that ends the first IDLE cycle after completion.
REQ-032 IM_enable_fetch and IM_enable_write SHALL never be high together; either strobe high implies IM_enable_mem high.
REQ-033 fetch_ack, wr_ack and fetch_valid SHALL each be high for exactly one cycle per transaction.
REQ-034 Requests arriving while busy SHALL be ignored until IDLE; they must remain asserted to be served.
REQ-035 Addresses SHALL be passed unmodified; there is no wrap or offset arithmetic (the address range is the full 2^addr_size).
REQ-036 A request deasserted before its grant SHALL be dropped with no side effect.

Reset
REQ-037 On reset, in any state:
- state <= IDLE, last_grant <= fetch
- all outputs <= 0: IM_address, IMin, enables, acks, fetch_valid, fetch_data, busy
REQ-038 Reset during RD_ISSUE or RD_DATA SHALL abort the fetch with no fetch_valid.
REQ-039 Reset during WR_ISSUE SHALL drop the enables at that edge; the memory's own reset has priority over the pending write.
REQ-040 reset has priority over every request in the same cycle.

Verification
REQ-041 Single write then fetch:
- stimulus: wr_req with addr 0x005, data 0xDEADBEEF; then fetch_req addr 0x005
- required: wr_ack in cycle 1; fetch_valid in cycle 3 of the fetch, fetch_data = 0xDEADBEEF
REQ-042 Simultaneous requests after reset, held continuously:
- stimulus: wr_req and fetch_req both asserted
- required: write granted first, then the fetch, then alternation; never two consecutive grants to one side while the other waits
REQ-043 Back-to-back writes:
- stimulus: 4 writes to addresses 0x3FC-0x3FF with data 1-4
- required: wr_ack pulses 2 cycles apart; 4 fetches return 1, 2, 3, 4
REQ-044 Reset mid-fetch:
- stimulus: reset asserted in RD_DATA
- required: no fetch_valid, busy = 0 the next cycle, all IM enables 0
REQ-045 Request held while busy:
- stimulus: fetch_req asserted during WR_ISSUE
- required: fetch granted on the edge ending the following IDLE cycle; exactly one fetch_ack
REQ-046 Invariants, checked every cycle: the strobe exclusivity of REQ-032 and busy consistent with state.
